// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready byte input into a small FIFO, then a
// start/data/parity/stop frame engine that chains queued frames with no idle gap.
module uart_tx_param #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        tx_enable,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLK_DIV - 1);
    localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;
    logic                 unused_in_bits;

    state_e               state_q;
    logic [CW-1:0]        baud_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 baud_last, frame_done;

    assign unused_in_bits = ^in_data;
    assign fifo_empty     = (count_q == '0);
    assign in_ready       = (count_q != FULL_COUNT);
    assign fifo_count     = count_q;
    assign push           = in_valid && in_ready;
    assign head           = mem_q[rd_ptr_q];

    assign baud_last  = (baud_q == BAUD_LAST);
    assign frame_done = (state_q == STOP) && baud_last && (bit_q == STOP_LAST);
    // Loading from IDLE or straight out of the last stop cycle is what makes frames gapless.
    assign pop        = !fifo_empty && tx_enable && ((state_q == IDLE) || frame_done);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else if (pop) begin
            state_q  <= START;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= head;
            parity_q <= (^head) ^ (PARITY == 1);
            tx       <= 1'b0;
            busy     <= 1'b1;
        end else if (state_q != IDLE) begin
            if (!baud_last) begin
                baud_q <= baud_q + 1'b1;
            end else begin
                baud_q <= '0;
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx      <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= PAR;
                                tx      <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx      <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx      <= shift_q[1];
                        end
                    end
                    PAR: begin
                        state_q <= STOP;
                        tx      <= 1'b1;
                    end
                    STOP: begin
                        if (bit_q == STOP_LAST) begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        tx      <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8N1 instance and two 7-bit/2-stop instances (even and odd
// parity), each compared cycle by cycle against line waveforms built from the frame rules.
module tb_uart_tx_param;
    localparam int DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] aData;
    logic       aValid, aReady, aEnable, aTx, aBusy;
    logic [2:0] aCount;
    logic [7:0] pData;
    logic       pValid, pEnable;
    logic       bReady, bTx, bBusy, cReady, cTx, cBusy;
    logic [2:0] bCount, cCount;

    int checks   = 0;
    int failures = 0;

    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
        .clk(clk), .rst(rst), .in_data(aData), .in_valid(aValid), .in_ready(aReady),
        .tx_enable(aEnable), .tx(aTx), .busy(aBusy), .fifo_count(aCount));

    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .rst(rst), .in_data(pData), .in_valid(pValid), .in_ready(bReady),
        .tx_enable(pEnable), .tx(bTx), .busy(bBusy), .fifo_count(bCount));

    uart_tx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dutC (
        .clk(clk), .rst(rst), .in_data(pData), .in_valid(pValid), .in_ready(cReady),
        .tx_enable(pEnable), .tx(cTx), .busy(cBusy), .fifo_count(cCount));

    // Line bits of one frame in send order; positions past the parity bit stay 1 (stop/idle).
    function automatic logic [15:0] frameBits(input logic [7:0] d, input int nData, input int par);
        logic [15:0] f;
        int ones;
        int pos;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        pos  = 1;
        for (int i = 0; i < nData; i++) begin
            f[pos] = d[i];
            ones += int'(d[i]);
            pos++;
        end
        if (par == 2) f[pos] = (ones % 2 != 0);
        if (par == 1) f[pos] = (ones % 2 == 0);
        return f;
    endfunction

    function automatic int frameLen(input int nData, input int par, input int nStop);
        return (1 + nData + ((par != 0) ? 1 : 0) + nStop) * DIV;
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; aValid = 1'b0; aData = '0; aEnable = 1'b1;
        pValid = 1'b0; pData = '0; pEnable = 1'b1;
        repeat (3) applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checks++;
        if ({aTx, aBusy, aReady, aCount} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            failures++;
            $display("[TB] FAIL reset_a actual=%b expected=%b", {aTx, aBusy, aReady, aCount}, 6'b101000);
        end
        checks++;
        if ({bTx, bBusy, bReady, bCount, cTx, cBusy, cReady, cCount} !== 12'b101000_101000) begin
            failures++;
            $display("[TB] FAIL reset_bc actual=%b expected=%b",
                     {bTx, bBusy, bReady, bCount, cTx, cBusy, cReady, cCount}, 12'b101000_101000);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] fb;
        int len;
        fb  = frameBits(8'h53, 8, 0);
        len = frameLen(8, 0, 1);
        aData = 8'h53; aValid = 1'b1;
        applyStimulus();
        aValid = 1'b0;
        checks++;
        if (aTx !== 1'b1 || aCount !== 3'd1) begin
            failures++;
            $display("[TB] FAIL push_edge actual=tx%b/cnt%0d expected=tx1/cnt1", aTx, aCount);
        end
        applyStimulus();
        for (int k = 0; k < len; k++) begin
            checks++;
            if (aTx !== fb[k / DIV] || aBusy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL frame_53 k=%0d actual=tx%b/busy%b expected=tx%b/busy1", k, aTx, aBusy, fb[k / DIV]);
            end
            applyStimulus();
        end
        checks++;
        if (aTx !== 1'b1 || aBusy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_53_end actual=tx%b/busy%b expected=tx1/busy0", aTx, aBusy);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0]  d;
        logic [15:0] fb;
        int len;
        len = frameLen(8, 0, 1);
        for (int n = 0; n < 4; n++) begin
            d  = 8'($urandom);
            fb = frameBits(d, 8, 0);
            repeat ($urandom_range(0, 5)) applyStimulus();
            aData = d; aValid = 1'b1;
            applyStimulus();
            aValid = 1'b0;
            applyStimulus();
            for (int k = 0; k < len; k++) begin
                checks++;
                if (aTx !== fb[k / DIV]) begin
                    failures++;
                    $display("[TB] FAIL rand_frame d=%h k=%0d actual=%b expected=%b", d, k, aTx, fb[k / DIV]);
                end
                applyStimulus();
            end
            checks++;
            if (aBusy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rand_frame_end actual=busy%b expected=busy0", aBusy);
            end
        end
    endtask

    task automatic test_parity_format();
        logic [7:0]  d;
        logic [15:0] fbB, fbC;
        int len;
        len = frameLen(7, 2, 2);
        for (int n = 0; n < 4; n++) begin
            d   = (n == 0) ? 8'h55 : 8'($urandom);
            fbB = frameBits(d, 7, 2);
            fbC = frameBits(d, 7, 1);
            pData = d; pValid = 1'b1;
            applyStimulus();
            pValid = 1'b0;
            applyStimulus();
            for (int k = 0; k < len; k++) begin
                checks++;
                if (bTx !== fbB[k / DIV]) begin
                    failures++;
                    $display("[TB] FAIL even_frame d=%h k=%0d actual=%b expected=%b", d, k, bTx, fbB[k / DIV]);
                end
                checks++;
                if (cTx !== fbC[k / DIV]) begin
                    failures++;
                    $display("[TB] FAIL odd_frame d=%h k=%0d actual=%b expected=%b", d, k, cTx, fbC[k / DIV]);
                end
                applyStimulus();
            end
            checks++;
            if ({bBusy, cBusy, bTx, cTx} !== 4'b0011) begin
                failures++;
                $display("[TB] FAIL parity_end actual=%b expected=0011", {bBusy, cBusy, bTx, cTx});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b [5];
        logic [15:0] fb [5];
        logic        expTx, expBusy;
        int len, k, cnt;
        len = frameLen(8, 0, 1);
        for (int i = 0; i < 5; i++) begin
            b[i]  = 8'($urandom);
            fb[i] = frameBits(b[i], 8, 0);
        end
        aData = b[0]; aValid = 1'b1;
        for (int c = 0; c <= 5 * len + 2; c++) begin
            applyStimulus();
            if (c <= 4) begin
                cnt = (c == 0) ? 1 : c;
                checks++;
                if (aReady !== (cnt < 4) || aCount !== 3'(cnt)) begin
                    failures++;
                    $display("[TB] FAIL b2b_fill c=%0d actual=rdy%b/cnt%0d expected=rdy%b/cnt%0d",
                             c, aReady, aCount, (cnt < 4), cnt);
                end
            end
            k       = c - 1;
            expTx   = (c == 0 || k >= 5 * len) ? 1'b1 : fb[k / len][(k % len) / DIV];
            expBusy = (c >= 1 && k < 5 * len);
            checks++;
            if (aTx !== expTx || aBusy !== expBusy) begin
                failures++;
                $display("[TB] FAIL b2b_line c=%0d actual=tx%b/busy%b expected=tx%b/busy%b",
                         c, aTx, aBusy, expTx, expBusy);
            end
            if (c < 4) begin
                aData = b[c + 1];
            end else begin
                aValid = 1'b0;
            end
        end
    endtask

    task automatic test_tx_enable();
        logic [7:0]  d0, d1;
        logic [15:0] f0, f1;
        int len;
        len = frameLen(8, 0, 1);
        d0 = 8'($urandom); d1 = 8'($urandom);
        f0 = frameBits(d0, 8, 0); f1 = frameBits(d1, 8, 0);
        aEnable = 1'b0;
        aData = d0; aValid = 1'b1;
        applyStimulus();
        aData = d1;
        applyStimulus();
        aValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({aTx, aBusy, aCount} !== {1'b1, 1'b0, 3'd2}) begin
                failures++;
                $display("[TB] FAIL gate_hold actual=tx%b/busy%b/cnt%0d expected=tx1/busy0/cnt2", aTx, aBusy, aCount);
            end
            applyStimulus();
        end
        aEnable = 1'b1;
        applyStimulus();
        for (int k = 0; k < len; k++) begin
            checks++;
            if (aTx !== f0[k / DIV]) begin
                failures++;
                $display("[TB] FAIL gate_frame0 k=%0d actual=%b expected=%b", k, aTx, f0[k / DIV]);
            end
            if (k == 10) aEnable = 1'b0;
            applyStimulus();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({aTx, aBusy, aCount} !== {1'b1, 1'b0, 3'd1}) begin
                failures++;
                $display("[TB] FAIL gate_pause actual=tx%b/busy%b/cnt%0d expected=tx1/busy0/cnt1", aTx, aBusy, aCount);
            end
            applyStimulus();
        end
        aEnable = 1'b1;
        applyStimulus();
        for (int k = 0; k < len; k++) begin
            checks++;
            if (aTx !== f1[k / DIV]) begin
                failures++;
                $display("[TB] FAIL gate_frame1 k=%0d actual=%b expected=%b", k, aTx, f1[k / DIV]);
            end
            applyStimulus();
        end
        checks++;
        if ({aTx, aBusy, aCount} !== {1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("[TB] FAIL gate_end actual=tx%b/busy%b/cnt%0d expected=tx1/busy0/cnt0", aTx, aBusy, aCount);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0]  d0;
        logic [15:0] f0;
        d0 = 8'($urandom);
        f0 = frameBits(d0, 8, 0);
        aEnable = 1'b1;
        aData = d0; aValid = 1'b1;
        applyStimulus();
        aData = 8'($urandom);
        applyStimulus();
        aValid = 1'b0;
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (aTx !== f0[k / DIV]) begin
                failures++;
                $display("[TB] FAIL abort_pre k=%0d actual=%b expected=%b", k, aTx, f0[k / DIV]);
            end
            applyStimulus();
        end
        checks++;
        if (aTx !== d0[3] || aCount !== 3'd1) begin
            failures++;
            $display("[TB] FAIL abort_bit3 actual=tx%b/cnt%0d expected=tx%b/cnt1", aTx, aCount, d0[3]);
        end
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checks++;
        if ({aTx, aBusy, aCount, aReady} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL abort_edge actual=%b expected=100001", {aTx, aBusy, aCount, aReady});
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            checks++;
            if (aTx !== 1'b1 || aBusy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_quiet i=%0d actual=tx%b/busy%b expected=tx1/busy0", i, aTx, aBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_frames();
        test_parity_format();
        test_back_to_back();
        test_tx_enable();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
